// File: rtl/decode_queue.sv
// decode_queue: RV32I(+M) decode stage feeding a DEPTH-entry bundle FIFO.
// Fetch words are decoded combinationally when accepted. The decoded bundle is
// written into the FIFO, and execute drains the FIFO over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all queued bundles
//   in_valid/in_ready fetch handshake; in_inst, in_pc fetched word and its PC
//   out_valid/out_ready execute handshake for the head bundle
//   out_flags         one-hot operation flags (M ops in the top 8 bits when EN_M=1)
//   out_rd/rs1/rs2    register fields; out_imm decoded immediate; out_pc bundle PC
//   out_illegal       head bundle is an illegal instruction
//   illegal_cnt       saturating count of illegal words accepted
module decode_queue #(
    parameter int DEPTH = 2,
    parameter int EN_M  = 0,
    parameter int PC_W  = 32,
    parameter int CNT_W = 8,
    localparam int FLAGS_W = 48 + 8 * EN_M
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [31:0]        out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Flag bit positions in the base vector
    localparam int F_BNE = 47, F_BLTU = 46, F_BLT = 45, F_BGEU = 44, F_BGE = 43, F_BEQ = 42;
    localparam int F_ADDI = 41, F_SLTI = 40, F_SLTIU = 39, F_XORI = 38, F_ORI = 37, F_ANDI = 36;
    localparam int F_SLLI = 35, F_SRLI = 34, F_SRAI = 33;
    localparam int F_ADD = 32, F_SUB = 31, F_SLL = 30, F_SLT = 29, F_SLTU = 28, F_XOR = 27;
    localparam int F_OR = 26, F_AND = 25;
    localparam int F_LB = 24, F_LH = 23, F_LW = 22, F_LBU = 21, F_LHU = 20;
    localparam int F_SB = 19, F_SH = 18, F_SW = 17;
    localparam int F_CSRRW = 16, F_CSRRS = 15, F_CSRRC = 14, F_CSRRWI = 13, F_CSRRSI = 12;
    localparam int F_CSRRCI = 11, F_SRET = 10, F_WFI = 9, F_MRET = 8, F_ECALL = 7, F_EBREAK = 6;
    localparam int F_JALR = 5, F_JAL = 4, F_AUIPC = 3, F_LUI = 2, F_SRA = 1, F_SRL = 0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_inst[6:2];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Stage p0: combinational decode of the word presented by fetch
    logic [FLAGS_W-1:0]  dec_flags_p0;
    logic [4:0]          dec_rd_p0, dec_rs1_p0, dec_rs2_p0;
    logic signed [31:0]  dec_imm_p0;
    logic                dec_ill_p0;

    always_comb begin
        dec_flags_p0 = '0;
        dec_rd_p0    = '0;
        dec_rs1_p0   = '0;
        dec_rs2_p0   = '0;
        dec_imm_p0   = '0;
        dec_ill_p0   = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_ill_p0 = 1'b1;
        end else begin
            case (opc)
                5'b01101: begin dec_flags_p0[F_LUI]   = 1'b1; dec_rd_p0 = in_inst[11:7]; dec_imm_p0 = imm_u; end
                5'b00101: begin dec_flags_p0[F_AUIPC] = 1'b1; dec_rd_p0 = in_inst[11:7]; dec_imm_p0 = imm_u; end
                5'b11011: begin dec_flags_p0[F_JAL]   = 1'b1; dec_rd_p0 = in_inst[11:7]; dec_imm_p0 = imm_j; end
                5'b11001: begin
                    dec_flags_p0[F_JALR] = 1'b1;
                    dec_rd_p0  = in_inst[11:7];
                    dec_rs1_p0 = in_inst[19:15];
                    dec_imm_p0 = imm_i;
                    if (f3 != 3'b000) dec_ill_p0 = 1'b1;
                end
                5'b11000: begin
                    dec_rs1_p0 = in_inst[19:15];
                    dec_rs2_p0 = in_inst[24:20];
                    dec_imm_p0 = imm_b;
                    case (f3)
                        3'b000:  dec_flags_p0[F_BEQ]  = 1'b1;
                        3'b001:  dec_flags_p0[F_BNE]  = 1'b1;
                        3'b100:  dec_flags_p0[F_BLT]  = 1'b1;
                        3'b101:  dec_flags_p0[F_BGE]  = 1'b1;
                        3'b110:  dec_flags_p0[F_BLTU] = 1'b1;
                        3'b111:  dec_flags_p0[F_BGEU] = 1'b1;
                        default: dec_ill_p0 = 1'b1;
                    endcase
                end
                5'b00000: begin
                    dec_rd_p0  = in_inst[11:7];
                    dec_rs1_p0 = in_inst[19:15];
                    dec_imm_p0 = imm_i;
                    case (f3)
                        3'b000:  dec_flags_p0[F_LB]  = 1'b1;
                        3'b001:  dec_flags_p0[F_LH]  = 1'b1;
                        3'b010:  dec_flags_p0[F_LW]  = 1'b1;
                        3'b100:  dec_flags_p0[F_LBU] = 1'b1;
                        3'b101:  dec_flags_p0[F_LHU] = 1'b1;
                        default: dec_ill_p0 = 1'b1;
                    endcase
                end
                5'b01000: begin
                    dec_rs1_p0 = in_inst[19:15];
                    dec_rs2_p0 = in_inst[24:20];
                    dec_imm_p0 = imm_s;
                    case (f3)
                        3'b000:  dec_flags_p0[F_SB] = 1'b1;
                        3'b001:  dec_flags_p0[F_SH] = 1'b1;
                        3'b010:  dec_flags_p0[F_SW] = 1'b1;
                        default: dec_ill_p0 = 1'b1;
                    endcase
                end
                5'b00100: begin
                    dec_rd_p0  = in_inst[11:7];
                    dec_rs1_p0 = in_inst[19:15];
                    dec_imm_p0 = imm_i;
                    case (f3)
                        3'b000: dec_flags_p0[F_ADDI]  = 1'b1;
                        3'b010: dec_flags_p0[F_SLTI]  = 1'b1;
                        3'b011: dec_flags_p0[F_SLTIU] = 1'b1;
                        3'b100: dec_flags_p0[F_XORI]  = 1'b1;
                        3'b110: dec_flags_p0[F_ORI]   = 1'b1;
                        3'b111: dec_flags_p0[F_ANDI]  = 1'b1;
                        3'b001: begin
                            dec_imm_p0 = {27'b0, in_inst[24:20]};
                            if (f7 == 7'b0000000) dec_flags_p0[F_SLLI] = 1'b1;
                            else                  dec_ill_p0 = 1'b1;
                        end
                        default: begin
                            dec_imm_p0 = {27'b0, in_inst[24:20]};
                            if (f7 == 7'b0000000)      dec_flags_p0[F_SRLI] = 1'b1;
                            else if (f7 == 7'b0100000) dec_flags_p0[F_SRAI] = 1'b1;
                            else                       dec_ill_p0 = 1'b1;
                        end
                    endcase
                end
                5'b01100: begin
                    dec_rd_p0  = in_inst[11:7];
                    dec_rs1_p0 = in_inst[19:15];
                    dec_rs2_p0 = in_inst[24:20];
                    if (f7 == 7'b0000000) begin
                        case (f3)
                            3'b000:  dec_flags_p0[F_ADD]  = 1'b1;
                            3'b001:  dec_flags_p0[F_SLL]  = 1'b1;
                            3'b010:  dec_flags_p0[F_SLT]  = 1'b1;
                            3'b011:  dec_flags_p0[F_SLTU] = 1'b1;
                            3'b100:  dec_flags_p0[F_XOR]  = 1'b1;
                            3'b101:  dec_flags_p0[F_SRL]  = 1'b1;
                            3'b110:  dec_flags_p0[F_OR]   = 1'b1;
                            default: dec_flags_p0[F_AND]  = 1'b1;
                        endcase
                    end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                        dec_flags_p0[F_SUB] = 1'b1;
                    end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                        dec_flags_p0[F_SRA] = 1'b1;
                    end else if (f7 == 7'b0000001 && EN_M != 0) begin
                        // M ops occupy the top byte, mul at the MSB down to remu
                        dec_flags_p0[FLAGS_W-1 -: 8] = 8'b1000_0000 >> f3;
                    end else begin
                        dec_ill_p0 = 1'b1;
                    end
                end
                5'b00011: begin
                    if (f3 != 3'b000 && f3 != 3'b001) dec_ill_p0 = 1'b1;
                end
                5'b11100: begin
                    if (f3 == 3'b000) begin
                        case (in_inst)
                            32'h0000_0073: dec_flags_p0[F_ECALL]  = 1'b1;
                            32'h0010_0073: dec_flags_p0[F_EBREAK] = 1'b1;
                            32'h1020_0073: dec_flags_p0[F_SRET]   = 1'b1;
                            32'h1050_0073: dec_flags_p0[F_WFI]    = 1'b1;
                            32'h3020_0073: dec_flags_p0[F_MRET]   = 1'b1;
                            default:       dec_ill_p0 = 1'b1;
                        endcase
                    end else begin
                        // CSR ops: rs1 field doubles as zimm for the immediate forms
                        dec_rd_p0  = in_inst[11:7];
                        dec_rs1_p0 = in_inst[19:15];
                        dec_imm_p0 = {20'b0, in_inst[31:20]};
                        case (f3)
                            3'b001:  dec_flags_p0[F_CSRRW]  = 1'b1;
                            3'b010:  dec_flags_p0[F_CSRRS]  = 1'b1;
                            3'b011:  dec_flags_p0[F_CSRRC]  = 1'b1;
                            3'b101:  dec_flags_p0[F_CSRRWI] = 1'b1;
                            3'b110:  dec_flags_p0[F_CSRRSI] = 1'b1;
                            3'b111:  dec_flags_p0[F_CSRRCI] = 1'b1;
                            default: dec_ill_p0 = 1'b1;
                        endcase
                    end
                end
                default: dec_ill_p0 = 1'b1;
            endcase
        end
        if (dec_ill_p0) begin
            dec_flags_p0 = '0;
            dec_rd_p0    = '0;
            dec_rs1_p0   = '0;
            dec_rs2_p0   = '0;
            dec_imm_p0   = '0;
        end
    end

    // Stage p1: FIFO storage and pointer control
    logic [FLAGS_W-1:0]  fifo_flags_p1 [DEPTH];
    logic [4:0]          fifo_rd_p1    [DEPTH];
    logic [4:0]          fifo_rs1_p1   [DEPTH];
    logic [4:0]          fifo_rs2_p1   [DEPTH];
    logic signed [31:0]  fifo_imm_p1   [DEPTH];
    logic [PC_W-1:0]     fifo_pc_p1    [DEPTH];
    logic                fifo_ill_p1   [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, push, enq, pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign in_ready  = !full && !flush;
    assign push      = in_valid && in_ready;
    // All-zero words are bubbles: accepted from fetch but never stored or counted
    assign enq       = push && (in_inst != 32'h0);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (enq && dec_ill_p0) illegal_cnt <= sat_inc(illegal_cnt);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (enq && !pop)      count <= count + 1'b1;
                else if (!enq && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_flags_p1[wr_ptr] <= dec_flags_p0;
            fifo_rd_p1[wr_ptr]    <= dec_rd_p0;
            fifo_rs1_p1[wr_ptr]   <= dec_rs1_p0;
            fifo_rs2_p1[wr_ptr]   <= dec_rs2_p0;
            fifo_imm_p1[wr_ptr]   <= dec_imm_p0;
            fifo_pc_p1[wr_ptr]    <= in_pc;
            fifo_ill_p1[wr_ptr]   <= dec_ill_p0;
        end
    end

    // Data outputs are forced to zero whenever no bundle is presented
    assign out_flags   = out_valid ? fifo_flags_p1[rd_ptr] : '0;
    assign out_rd      = out_valid ? fifo_rd_p1[rd_ptr]    : '0;
    assign out_rs1     = out_valid ? fifo_rs1_p1[rd_ptr]   : '0;
    assign out_rs2     = out_valid ? fifo_rs2_p1[rd_ptr]   : '0;
    assign out_imm     = out_valid ? fifo_imm_p1[rd_ptr]   : '0;
    assign out_pc      = out_valid ? fifo_pc_p1[rd_ptr]    : '0;
    assign out_illegal = out_valid ? fifo_ill_p1[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [47:0] a_out_flags;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [31:0] a_out_imm, a_out_pc;
    logic [7:0]  a_cnt;

    logic        m_in_ready, m_out_valid, m_out_illegal;
    logic [55:0] m_out_flags;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [31:0] m_out_imm, m_out_pc;
    logic [7:0]  m_cnt;

    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [47:0] c_out_flags;
    logic [4:0]  c_out_rd, c_out_rs1, c_out_rs2;
    logic [31:0] c_out_imm, c_out_pc;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [47:0] F_ADDI   = 48'd1 << 41;
    localparam logic [47:0] F_BEQ    = 48'd1 << 42;
    localparam logic [47:0] F_EBREAK = 48'd1 << 6;
    localparam logic [47:0] F_ECALL  = 48'd1 << 7;
    localparam logic [47:0] F_MRET   = 48'd1 << 8;
    localparam logic [47:0] F_SW     = 48'd1 << 17;
    localparam logic [47:0] F_LUI    = 48'd1 << 2;
    localparam logic [47:0] F_JAL    = 48'd1 << 4;
    localparam logic [47:0] F_SRAI   = 48'd1 << 33;
    localparam logic [47:0] F_CSRRSI = 48'd1 << 12;
    localparam logic [47:0] F_SUB    = 48'd1 << 31;
    localparam logic [55:0] F_MUL    = 56'd1 << 55;

    always #5 clk = ~clk;

    decode_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_flags(a_out_flags), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_imm(a_out_imm), .out_pc(a_out_pc), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
    );

    decode_queue #(.EN_M(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_flags(m_out_flags), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_imm(m_out_imm), .out_pc(m_out_pc), .out_illegal(m_out_illegal), .illegal_cnt(m_cnt)
    );

    decode_queue #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_flags(c_out_flags), .out_rd(c_out_rd), .out_rs1(c_out_rs1), .out_rs2(c_out_rs2),
        .out_imm(c_out_imm), .out_pc(c_out_pc), .out_illegal(c_out_illegal), .illegal_cnt(c_cnt)
    );

    // Drive one cycle of inputs starting at a falling edge; returns at the next falling edge
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_out_valid); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", a_in_ready); else n_pass++;
        n_checks++; if (a_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", a_cnt); else n_pass++;
        n_checks++; if (a_out_flags !== 48'd0) $display("FAIL rst_flags: got %h want 0", a_out_flags); else n_pass++;
        n_checks++; if (a_out_imm !== 32'd0 || a_out_pc !== 32'd0) $display("FAIL rst_data: got imm %h pc %h want 0", a_out_imm, a_out_pc); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi;
        cyc(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        n_checks++; if (a_out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", a_out_valid); else n_pass++;
        n_checks++; if (a_out_flags !== F_ADDI) $display("FAIL addi_flags: got %h want %h", a_out_flags, F_ADDI); else n_pass++;
        n_checks++; if (a_out_rd !== 5'd1 || a_out_rs1 !== 5'd0) $display("FAIL addi_regs: got rd %0d rs1 %0d want 1 0", a_out_rd, a_out_rs1); else n_pass++;
        n_checks++; if (a_out_imm !== 32'h5) $display("FAIL addi_imm: got %h want 00000005", a_out_imm); else n_pass++;
        n_checks++; if (a_out_pc !== 32'h100 || a_out_illegal !== 1'b0) $display("FAIL addi_pc_ill: got %h %b want 00000100 0", a_out_pc, a_out_illegal); else n_pass++;
        n_checks++; if (a_cnt !== 8'd0) $display("FAIL addi_cnt: got %0d want 0", a_cnt); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0 || a_out_flags !== 48'd0) $display("FAIL addi_pop: got valid %b flags %h want 0 0", a_out_valid, a_out_flags); else n_pass++;
    endtask

    task automatic test_branch_system;
        cyc(1'b1, 32'hFE00_0EE3, 32'h200, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_BEQ) $display("FAIL beq_flags: got %h want %h", a_out_flags, F_BEQ); else n_pass++;
        n_checks++; if (a_out_imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm: got %h want fffffffc", a_out_imm); else n_pass++;
        cyc(1'b1, 32'h0010_0073, 32'h204, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_EBREAK || a_out_pc !== 32'h204) $display("FAIL ebreak: got %h pc %h want %h 00000204", a_out_flags, a_out_pc, F_EBREAK); else n_pass++;
        cyc(1'b1, 32'h0000_0073, 32'h208, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_ECALL || a_out_imm !== 32'd0) $display("FAIL ecall: got %h imm %h want %h 0", a_out_flags, a_out_imm, F_ECALL); else n_pass++;
        cyc(1'b1, 32'h3020_0073, 32'h20C, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_MRET) $display("FAIL mret: got %h want %h", a_out_flags, F_MRET); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL sys_drain: got %b want 0", a_out_valid); else n_pass++;
    endtask

    task automatic test_imm_forms;
        cyc(1'b1, 32'h0020_A423, 32'h300, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_SW || a_out_imm !== 32'd8 || a_out_rs1 !== 5'd1 || a_out_rs2 !== 5'd2)
            $display("FAIL sw: got %h imm %h rs1 %0d rs2 %0d want %h 8 1 2", a_out_flags, a_out_imm, a_out_rs1, a_out_rs2, F_SW); else n_pass++;
        cyc(1'b1, 32'h1234_52B7, 32'h304, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_LUI || a_out_imm !== 32'h1234_5000 || a_out_rd !== 5'd5)
            $display("FAIL lui: got %h imm %h rd %0d want %h 12345000 5", a_out_flags, a_out_imm, a_out_rd, F_LUI); else n_pass++;
        cyc(1'b1, 32'hFF9F_F0EF, 32'h308, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_JAL || a_out_imm !== 32'hFFFF_FFF8 || a_out_rd !== 5'd1)
            $display("FAIL jal: got %h imm %h rd %0d want %h fffffff8 1", a_out_flags, a_out_imm, a_out_rd, F_JAL); else n_pass++;
        cyc(1'b1, 32'h4030_D093, 32'h30C, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_SRAI || a_out_imm !== 32'd3)
            $display("FAIL srai: got %h imm %h want %h 3", a_out_flags, a_out_imm, F_SRAI); else n_pass++;
        cyc(1'b1, 32'h3002_E1F3, 32'h310, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_CSRRSI || a_out_imm !== 32'h300 || a_out_rs1 !== 5'd5 || a_out_rd !== 5'd3)
            $display("FAIL csrrsi: got %h imm %h rs1 %0d rd %0d want %h 300 5 3", a_out_flags, a_out_imm, a_out_rs1, a_out_rd, F_CSRRSI); else n_pass++;
        cyc(1'b1, 32'h4020_81B3, 32'h314, 1'b1, 1'b0);
        n_checks++; if (a_out_flags !== F_SUB || a_out_imm !== 32'd0 || a_out_rd !== 5'd3)
            $display("FAIL sub: got %h imm %h rd %0d want %h 0 3", a_out_flags, a_out_imm, a_out_rd, F_SUB); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_full;
        cyc(1'b1, 32'h0010_0093, 32'h400, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL full_ready1: got %b want 1", a_in_ready); else n_pass++;
        cyc(1'b1, 32'h0020_0113, 32'h404, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL full_ready2: got %b want 0", a_in_ready); else n_pass++;
        cyc(1'b1, 32'h0030_0193, 32'h408, 1'b0, 1'b0);
        n_checks++; if (a_out_pc !== 32'h400 || a_out_rd !== 5'd1) $display("FAIL full_hold: got pc %h rd %0d want 00000400 1", a_out_pc, a_out_rd); else n_pass++;
        // Pop while full: the third word must still be refused this cycle
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL full_nopass: got %b want 0", a_in_ready); else n_pass++;
        cyc(1'b1, 32'h0030_0193, 32'h408, 1'b1, 1'b0);
        n_checks++; if (a_out_pc !== 32'h404 || a_out_rd !== 5'd2) $display("FAIL full_order2: got pc %h rd %0d want 00000404 2", a_out_pc, a_out_rd); else n_pass++;
        cyc(1'b1, 32'h0030_0193, 32'h408, 1'b1, 1'b0);
        n_checks++; if (a_out_pc !== 32'h408 || a_out_rd !== 5'd3) $display("FAIL full_order3: got pc %h rd %0d want 00000408 3", a_out_pc, a_out_rd); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL full_drain: got %b want 0", a_out_valid); else n_pass++;
    endtask

    task automatic test_illegal;
        cyc(1'b1, 32'h0000_0000, 32'h500, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd0) $display("FAIL zero_drop: got valid %b cnt %0d want 0 0", a_out_valid, a_cnt); else n_pass++;
        cyc(1'b1, 32'h0200_0033, 32'h504, 1'b1, 1'b0);
        n_checks++; if (a_out_illegal !== 1'b1 || a_out_flags !== 48'd0 || a_cnt !== 8'd1)
            $display("FAIL mul_nom: got ill %b flags %h cnt %0d want 1 0 1", a_out_illegal, a_out_flags, a_cnt); else n_pass++;
        n_checks++; if (m_out_flags !== F_MUL || m_out_illegal !== 1'b0 || m_cnt !== 8'd0)
            $display("FAIL mul_m: got flags %h ill %b cnt %0d want %h 0 0", m_out_flags, m_out_illegal, m_cnt, F_MUL); else n_pass++;
        cyc(1'b1, 32'h4000_E033, 32'h508, 1'b1, 1'b0);
        n_checks++; if (a_cnt !== 8'd2 || a_out_illegal !== 1'b1) $display("FAIL f7_or: got cnt %0d ill %b want 2 1", a_cnt, a_out_illegal); else n_pass++;
        n_checks++; if (m_cnt !== 8'd1) $display("FAIL f7_or_m: got cnt %0d want 1", m_cnt); else n_pass++;
        cyc(1'b1, 32'h0020_0073, 32'h50C, 1'b1, 1'b0);
        n_checks++; if (a_cnt !== 8'd3 || a_out_illegal !== 1'b1) $display("FAIL sys_bad: got cnt %0d ill %b want 3 1", a_cnt, a_out_illegal); else n_pass++;
        cyc(1'b1, 32'h0000_90E7, 32'h510, 1'b1, 1'b0);
        n_checks++; if (a_cnt !== 8'd4 || a_out_rd !== 5'd0 || a_out_imm !== 32'd0)
            $display("FAIL jalr_f3: got cnt %0d rd %0d imm %h want 4 0 0", a_cnt, a_out_rd, a_out_imm); else n_pass++;
        n_checks++; if (c_cnt !== 2'd3) $display("FAIL cnt2_sat_a: got %0d want 3", c_cnt); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        cyc(1'b1, 32'h0010_0093, 32'h600, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020_0113, 32'h604, 1'b0, 1'b0);
        n_checks++; if (a_out_valid !== 1'b1) $display("FAIL flush_fill: got %b want 1", a_out_valid); else n_pass++;
        cyc(1'b1, 32'hFFFF_FFFF, 32'h608, 1'b0, 1'b1);
        n_checks++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd4) $display("FAIL flush_full: got valid %b cnt %0d want 0 4", a_out_valid, a_cnt); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", a_in_ready); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("FAIL flush_after: got ready %b valid %b want 1 0", a_in_ready, a_out_valid); else n_pass++;
        cyc(1'b1, 32'h0010_0093, 32'h610, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFF, 32'h614, 1'b0, 1'b1);
        n_checks++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd4) $display("FAIL flush_part: got valid %b cnt %0d want 0 4", a_out_valid, a_cnt); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_idle: got %b want 0", a_out_valid); else n_pass++;
    endtask

    task automatic test_saturate;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 32'hFFFF_FFFF, 32'h700, 1'b1, 1'b0);
            n_checks++; if (c_cnt !== 2'((i > 3) ? 3 : i)) $display("FAIL sat_cnt%0d: got %0d want %0d", i, c_cnt, (i > 3) ? 3 : i); else n_pass++;
            n_checks++; if (a_cnt !== 8'(i)) $display("FAIL sat_wide%0d: got %0d want %0d", i, a_cnt, i); else n_pass++;
        end
        // Reset pulled low between clock edges while a push is being offered
        in_valid = 1'b1; in_inst = 32'hFFFF_FFFF; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (c_cnt !== 2'd0 || a_cnt !== 8'd0) $display("FAIL async_cnt: got %0d %0d want 0 0", c_cnt, a_cnt); else n_pass++;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL async_ctl: got valid %b ready %b want 0 1", a_out_valid, a_in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (c_cnt !== 2'd0 || a_out_valid !== 1'b0) $display("FAIL async_hold: got cnt %0d valid %b want 0 0", c_cnt, a_out_valid); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_branch_system;
        test_imm_forms;
        test_full;
        test_illegal;
        test_flush;
        test_saturate;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised RV32I(+M) instruction decode stage that sits between the fetch unit and the issue/execute stage. Each fetched word is decoded in the cycle it is accepted, and the full decoded bundle is pushed into a DEPTH-entry FIFO. The FIFO presents bundles to execute over a valid/ready handshake. The block adds RV32M decode, a FENCE no-op, strict funct7 checking, sign-extended immediates, all-zero bubble dropping, pipeline flush, and a saturating illegal-instruction counter.

## Interface
- DEPTH, 2, number of FIFO entries; power of two, ≥2.
- EN_M, 0, 1 decodes RV32M; FLAGS_W = 48 + 8·EN_M.
- PC_W, 32, program-counter width.
- CNT_W, 8, illegal-counter width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards the queue contents; synchronous.
- in_valid  in  1  fetch word is valid.
- in_ready  out  1  queue can accept a word.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  head bundle is valid.
- out_ready  in  1  execute consumes the head bundle.
- out_flags  out  FLAGS_W  one-hot operation flags. Bits [47:0], MSB→LSB: bne bltu blt bgeu bge beq addi slti sltiu xori ori andi slli srli srai add sub sll slt sltu xor or and lb lh lw lbu lhu sb sh sw csrrw csrrs csrrc csrrwi csrrsi csrrci sret wfi mret ecall ebreak jalr jal auipc lui sra srl. When EN_M=1, bits [55:48] are mul mulh mulhsu mulhu div divu rem remu.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_imm  out  32  decoded immediate.
- out_pc  out  PC_W  PC of the bundle.
- out_illegal  out  1  bundle is an illegal instruction.
- illegal_cnt  out  CNT_W  saturating count of illegal words accepted.

## Operation
- Push: in_valid && in_ready && !flush. Pop: out_valid && out_ready.
- Decode is combinational on in_inst; the result is stored at push.
- inst[1:0] ≠ 2'b11, an unknown opcode, or an unlisted funct3 → illegal.
- Any word marked illegal has flags=0, rd/rs1/rs2=0, imm=0 and out_illegal=1.
- in_inst == 32'h0: consumed at push, never enqueued, not counted.
- funct7 rules:
  - OP (01100): funct7 = 0000000 selects the base op. funct7 = 0100000 is legal only with funct3 000 (sub) and 101 (sra). funct7 = 0000001 selects the M ops when EN_M=1. All other cases are illegal.
  - OP-IMM shifts: funct7 = 0000000 for slli/srli, 0100000 for srai; anything else is illegal.
- JALR requires funct3 = 000; otherwise illegal.
- SYSTEM funct3 = 000 exact matches:
  - 0x00000073 → ecall; 0x00100073 → ebreak.
  - 0x10200073 → sret; 0x10500073 → wfi; 0x30200073 → mret.
  - Any other value → illegal.
  - SYSTEM funct3 = 100 → illegal.
- MISC-MEM (00011) with funct3 000 or 001 → legal, flags=0, imm=0. Other funct3 → illegal.
- out_imm:
  - I-type (including loads, jalr): sign-extended inst[31:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
  - B-type: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Shift-immediate: {27'b0, inst[24:20]}.
  - CSR: {20'b0, inst[31:20]}; rs1 carries zimm for the *i forms.
  - R-type and SYSTEM funct3 = 000: 0.
- FIFO:
  - in_ready = !full && !flush.
  - No pass-through: when full, in_ready=0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- flush: read pointer, write pointer and occupancy go to 0 at the edge. Any push in that cycle is discarded. illegal_cnt is unaffected.
- illegal_cnt increments on each push of an illegal word and saturates at 2^CNT_W−1. It is cleared only by rst_n.
- Whenever out_valid=0, all data outputs are driven 0.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, illegal_cnt=0.
  - All data outputs 0; pointers and occupancy 0.
- Latency: a push at edge N makes the bundle visible with out_valid=1 after edge N, when the queue was empty.
- Throughput: one bundle per cycle while not full and out_ready=1.
- Output data is stable while out_valid && !out_ready.
- rst_n asserted mid-operation clears all state immediately, without waiting for a clock edge.
- in_ready depends combinationally on flush; out_valid is purely registered.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) → next cycle out_valid=1, flags addi only, rd=1, rs1=0, imm=0x00000005, illegal_cnt=0.
- Push 0xFE000EE3 (beq x0,x0,−4), 0x00100073 and 0x00000073 → B-imm 0xFFFFFFFC with beq, then ebreak, then ecall.
- Hold out_ready=0 and push DEPTH+1 words → in_ready=0 after DEPTH pushes. The FIFO returns words in order with no loss when out_ready is raised.
- Push 0x00000000, then 0x02000033 with EN_M=0, then 0x4000E033 → the zero word is dropped, both later words are illegal, illegal_cnt=2. With EN_M=1, 0x02000033 decodes as mul.
- Fill 2 entries, assert flush together with in_valid → out_valid=0 next cycle, nothing enqueued, illegal_cnt unchanged.
- With CNT_W=2, push 5 illegal words (e.g. 0xFFFFFFFF) → illegal_cnt saturates at 3; asserting rst_n low mid-stream clears the count to 0 asynchronously.
